// File: rtl/calculator_pkg.sv
// Shared key codes, state encodings and small key-decoding helpers for the
// keypad calculator.
package calculator_pkg;

  localparam logic [3:0] KEY_A    = 4'd3;
  localparam logic [3:0] KEY_B    = 4'd7;
  localparam logic [3:0] KEY_C    = 4'd11;
  localparam logic [3:0] KEY_STAR = 4'd12;
  localparam logic [3:0] KEY_ZERO = 4'd13;
  localparam logic [3:0] KEY_HASH = 4'd14;
  localparam logic [3:0] KEY_D    = 4'd15;

  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL} op_t;

  typedef enum logic [1:0] {CTRL_OP1, CTRL_OP2, CTRL_CALC, CTRL_DONE} ctrl_state_t;

  typedef enum logic [1:0] {IC_SCAN, IC_DEBOUNCE, IC_DECODE, IC_HOLD} ic_state_t;

  // Digits occupy rows 0..2 / cols 0..2 plus the '0' key on the bottom row.
  function automatic logic key_is_digit(input logic [3:0] key);
    return ((key[1:0] != 2'd3) && (key[3:2] != 2'd3)) || (key == KEY_ZERO);
  endfunction

  function automatic logic [3:0] key_digit(input logic [3:0] key);
    if (key == KEY_ZERO)
      return 4'd0;
    return ({2'b00, key[3:2]} * 4'd3) + {2'b00, key[1:0]} + 4'd1;
  endfunction

  function automatic logic key_is_op(input logic [3:0] key);
    return (key == KEY_A) || (key == KEY_B) || (key == KEY_C);
  endfunction

  function automatic op_t key_op(input logic [3:0] key);
    case (key)
      KEY_A:   return OP_ADD;
      KEY_B:   return OP_SUB;
      default: return OP_MUL;
    endcase
  endfunction

  // magnitude*10 + digit, wrapping at 16 bits
  function automatic logic [15:0] append_digit(input logic [15:0] mag, input logic [3:0] d);
    return {mag[12:0], 3'b000} + {mag[14:0], 1'b0} + {12'd0, d};
  endfunction

endpackage

// File: rtl/keypad_scanner.sv
// Column scanner with per-row debounce; emits a one-cycle key_valid with the
// decoded row*4+col index, then holds until every row is released.
module keypad_scanner
  import calculator_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_index,
  output logic       key_valid,
  output ic_state_t  state
);

  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  ic_state_t     input_control_state;
  logic [1:0]    col_reg;
  logic [1:0]    row_reg;
  logic [1:0]    low_row;
  logic [CW-1:0] cnt_reg;
  logic          any_low;

  assign any_low = (row_in != 4'b1111);
  assign col_out = ~(4'b0001 << col_reg);
  assign state   = input_control_state;

  // Later assignments win, so the lowest-numbered low row is selected.
  always_comb begin
    low_row = 2'd3;
    if (!row_in[2]) low_row = 2'd2;
    if (!row_in[1]) low_row = 2'd1;
    if (!row_in[0]) low_row = 2'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      input_control_state <= IC_SCAN;
      col_reg             <= 2'd0;
      row_reg             <= 2'd0;
      cnt_reg             <= '0;
      key_index           <= 4'd0;
      key_valid           <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (!any_low)
        col_reg <= col_reg + 2'd1;
      case (input_control_state)
        IC_SCAN: begin
          if (any_low) begin
            row_reg             <= low_row;
            cnt_reg             <= CW'(1);
            input_control_state <= IC_DEBOUNCE;
          end
        end
        IC_DEBOUNCE: begin
          // The SCAN sample already counted as the first low sample.
          if (!row_in[row_reg]) begin
            if (cnt_reg >= CNT_LAST)
              input_control_state <= IC_DECODE;
            else
              cnt_reg <= cnt_reg + CW'(1);
          end else begin
            input_control_state <= IC_SCAN;
          end
        end
        IC_DECODE: begin
          key_index           <= {row_reg, col_reg};
          key_valid           <= 1'b1;
          input_control_state <= IC_HOLD;
        end
        IC_HOLD: begin
          if (!any_low)
            input_control_state <= IC_SCAN;
        end
        default: input_control_state <= IC_SCAN;
      endcase
    end
  end

endmodule

// File: rtl/calculator_top.sv
// Keypad calculator: scanner front end plus operand entry / arithmetic
// controller with a sequential shift-add multiplier.
module calculator_top
  import calculator_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic [3:0]  RowIn,
  output logic [3:0]  ColOut,
  output logic [15:0] display_output,
  output logic [1:0]  input_state_FPGA,
  output logic        complete,
  output logic        key_pressed
);

  ic_state_t   ic_state;
  logic [3:0]  key_index;
  logic        key_valid;

  keypad_scanner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) input_ctrl_inst (
    .clk       (clk),
    .rst       (nRST),
    .row_in    (RowIn),
    .col_out   (ColOut),
    .key_index (key_index),
    .key_valid (key_valid),
    .state     (ic_state)
  );

  assign input_state_FPGA = ic_state;
  assign key_pressed      = (ic_state == IC_HOLD);

  ctrl_state_t ctrl_state_reg;
  op_t         op_reg;
  logic [15:0] mag1_reg, mag2_reg, result_reg;
  logic        sign1_reg, sign2_reg;
  logic        key_read_reg;
  logic [15:0] mcand_reg, mplier_reg, acc_reg;
  logic [3:0]  mul_cnt_reg;
  logic [15:0] operand1, operand2, acc_sum;
  logic        consume;

  assign operand1 = sign1_reg ? (16'd0 - mag1_reg) : mag1_reg;
  assign operand2 = sign2_reg ? (16'd0 - mag2_reg) : mag2_reg;
  assign acc_sum  = acc_reg + (mplier_reg[0] ? mcand_reg : 16'd0);
  assign consume  = key_valid && !key_read_reg;
  assign complete = (ctrl_state_reg == CTRL_DONE);

  always_comb begin
    display_output = operand1;
    case (ctrl_state_reg)
      CTRL_OP2, CTRL_CALC: display_output = operand2;
      CTRL_DONE:           display_output = result_reg;
      default:             display_output = operand1;
    endcase
  end

  always_ff @(posedge clk or posedge nRST) begin : gencon_inst
    if (nRST) begin
      ctrl_state_reg <= CTRL_OP1;
      op_reg         <= OP_ADD;
      mag1_reg       <= 16'd0;
      mag2_reg       <= 16'd0;
      sign1_reg      <= 1'b0;
      sign2_reg      <= 1'b0;
      result_reg     <= 16'd0;
      key_read_reg   <= 1'b0;
      mcand_reg      <= 16'd0;
      mplier_reg     <= 16'd0;
      acc_reg        <= 16'd0;
      mul_cnt_reg    <= 4'd0;
    end else begin
      if (key_valid)
        key_read_reg <= 1'b1;
      else if (ic_state == IC_SCAN)
        key_read_reg <= 1'b0;

      case (ctrl_state_reg)
        CTRL_OP1: begin
          if (consume) begin
            if (key_is_digit(key_index))
              mag1_reg <= append_digit(mag1_reg, key_digit(key_index));
            else if (key_index == KEY_D)
              sign1_reg <= ~sign1_reg;
            else if (key_is_op(key_index)) begin
              op_reg         <= key_op(key_index);
              ctrl_state_reg <= CTRL_OP2;
            end
          end
        end
        CTRL_OP2: begin
          if (consume) begin
            if (key_is_digit(key_index))
              mag2_reg <= append_digit(mag2_reg, key_digit(key_index));
            else if (key_index == KEY_D)
              sign2_reg <= ~sign2_reg;
            else if (key_index == KEY_STAR) begin
              mcand_reg      <= operand1;
              mplier_reg     <= operand2;
              acc_reg        <= 16'd0;
              mul_cnt_reg    <= 4'd0;
              ctrl_state_reg <= CTRL_CALC;
            end
          end
        end
        CTRL_CALC: begin
          case (op_reg)
            OP_ADD: begin
              result_reg     <= operand1 + operand2;
              ctrl_state_reg <= CTRL_DONE;
            end
            OP_SUB: begin
              result_reg     <= operand1 - operand2;
              ctrl_state_reg <= CTRL_DONE;
            end
            default: begin
              // Low 16 bits of the two's-complement product equal the
              // unsigned product mod 2^16, so a plain 16-step shift-add works.
              acc_reg    <= acc_sum;
              mcand_reg  <= {mcand_reg[14:0], 1'b0};
              mplier_reg <= {1'b0, mplier_reg[15:1]};
              if (mul_cnt_reg == 4'd15) begin
                result_reg     <= acc_sum;
                ctrl_state_reg <= CTRL_DONE;
              end else begin
                mul_cnt_reg <= mul_cnt_reg + 4'd1;
              end
            end
          endcase
        end
        CTRL_DONE: begin
          if (consume) begin
            if (key_is_digit(key_index)) begin
              mag1_reg       <= {12'd0, key_digit(key_index)};
              sign1_reg      <= 1'b0;
              mag2_reg       <= 16'd0;
              sign2_reg      <= 1'b0;
              ctrl_state_reg <= CTRL_OP1;
            end else if (key_is_op(key_index)) begin
              mag1_reg       <= result_reg;
              sign1_reg      <= 1'b0;
              mag2_reg       <= 16'd0;
              sign2_reg      <= 1'b0;
              op_reg         <= key_op(key_index);
              ctrl_state_reg <= CTRL_OP2;
            end
          end
        end
        default: ctrl_state_reg <= CTRL_OP1;
      endcase
    end
  end

endmodule

// File: tb/tb_calculator_top.sv
// Directed key-sequence bench for calculator_top with a behavioural keypad.
module tb_calculator_top;

  logic        clk;
  logic        nRST;
  logic [3:0]  RowIn;
  logic [3:0]  ColOut;
  logic [15:0] display_output;
  logic [1:0]  input_state_FPGA;
  logic        complete;
  logic        key_pressed;

  calculator_top #(.DEBOUNCE_CYCLES(4)) dut (
    .clk              (clk),
    .nRST             (nRST),
    .RowIn            (RowIn),
    .ColOut           (ColOut),
    .display_output   (display_output),
    .input_state_FPGA (input_state_FPGA),
    .complete         (complete),
    .key_pressed      (key_pressed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad model: a held key pulls its row low only while its column is driven.
  logic       pressed;
  logic [1:0] prow, pcol;
  logic       glitch;

  always_comb begin
    RowIn = 4'b1111;
    if (glitch)
      RowIn = 4'b1110;
    else if (pressed && !ColOut[pcol])
      RowIn[prow] = 1'b0;
  end

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    string       keys;
    logic [15:0] exp_disp;
    logic        exp_done;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] char_key(input byte c);
    case (c)
      "1": return 4'd0;   "2": return 4'd1;   "3": return 4'd2;   "A": return 4'd3;
      "4": return 4'd4;   "5": return 4'd5;   "6": return 4'd6;   "B": return 4'd7;
      "7": return 4'd8;   "8": return 4'd9;   "9": return 4'd10;  "C": return 4'd11;
      "*": return 4'd12;  "0": return 4'd13;  "#": return 4'd14;  default: return 4'd15;
    endcase
  endfunction

  task automatic press(input logic [3:0] k);
    int t;
    @(negedge clk);
    prow = k[3:2];
    pcol = k[1:0];
    pressed = 1'b1;
    t = 0;
    while (!key_pressed && t < 60) begin
      @(negedge clk);
      t++;
    end
    check("key_accept", {31'd0, key_pressed}, 32'd1);
    repeat (2) @(negedge clk);
    pressed = 1'b0;
    t = 0;
    while (input_state_FPGA != 2'd0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic run_keys(input string s, input logic exp_done);
    int t;
    for (int j = 0; j < s.len(); j++)
      press(char_key(s[j]));
    t = 0;
    if (exp_done) begin
      while (!complete && t < 40) begin
        @(negedge clk);
        t++;
      end
    end else begin
      repeat (5) @(negedge clk);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_display"}, {16'd0, display_output}, 32'd0);
    check({tag, "_complete"}, {31'd0, complete}, 32'd0);
    check({tag, "_key_pressed"}, {31'd0, key_pressed}, 32'd0);
    check({tag, "_colout"}, {28'd0, ColOut}, 32'hE);
    check({tag, "_state"}, {30'd0, input_state_FPGA}, 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen_deb, seen_kp;

    vecs.push_back('{keys: "D3CD4*",   exp_disp: 16'd12,    exp_done: 1'b1});
    vecs.push_back('{keys: "3C4*",     exp_disp: 16'd12,    exp_done: 1'b1});
    vecs.push_back('{keys: "123A45*",  exp_disp: 16'd168,   exp_done: 1'b1});
    vecs.push_back('{keys: "123B45*",  exp_disp: 16'd78,    exp_done: 1'b1});
    vecs.push_back('{keys: "0B0*",     exp_disp: 16'd0,     exp_done: 1'b1});
    vecs.push_back('{keys: "256C256*", exp_disp: 16'd0,     exp_done: 1'b1});
    vecs.push_back('{keys: "32767A1*", exp_disp: 16'h8000,  exp_done: 1'b1});
    vecs.push_back('{keys: "A5*",      exp_disp: 16'h8005,  exp_done: 1'b1});
    vecs.push_back('{keys: "7#*",      exp_disp: 16'd7,     exp_done: 1'b0});
    vecs.push_back('{keys: "D",        exp_disp: 16'hFFF9,  exp_done: 1'b0});
    vecs.push_back('{keys: "B2D",      exp_disp: 16'hFFFE,  exp_done: 1'b0});
    vecs.push_back('{keys: "*",        exp_disp: 16'hFFFB,  exp_done: 1'b1});
    vecs.push_back('{keys: "*D#",      exp_disp: 16'hFFFB,  exp_done: 1'b1});
    vecs.push_back('{keys: "C3*",      exp_disp: 16'hFFF1,  exp_done: 1'b1});
    vecs.push_back('{keys: "9D",       exp_disp: 16'hFFF7,  exp_done: 1'b0});
    vecs.push_back('{keys: "C0*",      exp_disp: 16'd0,     exp_done: 1'b1});
    vecs.push_back('{keys: "70000",    exp_disp: 16'd4464,  exp_done: 1'b0});
    vecs.push_back('{keys: "A1*",      exp_disp: 16'd4465,  exp_done: 1'b1});

    pressed = 1'b0;
    prow    = 2'd0;
    pcol    = 2'd0;
    glitch  = 1'b0;
    nRST    = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    nRST = 1'b0;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) begin
      run_keys(vecs[i].keys, vecs[i].exp_done);
      $display("vector %0d keys=%s display=%0h complete=%0b", i, vecs[i].keys,
               display_output, complete);
      check({"disp_", vecs[i].keys}, {16'd0, display_output}, {16'd0, vecs[i].exp_disp});
      check({"done_", vecs[i].keys}, {31'd0, complete}, {31'd0, vecs[i].exp_done});
    end

    // Row low for one cycle fewer than the debounce length: no key accepted.
    seen_deb = 1'b0;
    seen_kp  = 1'b0;
    @(negedge clk);
    glitch = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (input_state_FPGA == 2'd1) seen_deb = 1'b1;
      if (key_pressed) seen_kp = 1'b1;
    end
    glitch = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (key_pressed) seen_kp = 1'b1;
    end
    $display("short glitch: debounce_seen=%0b key_pressed_seen=%0b display=%0h", seen_deb, seen_kp,
             display_output);
    check("short_glitch_debounce", {31'd0, seen_deb}, 32'd1);
    check("short_glitch_no_key", {31'd0, seen_kp}, 32'd0);
    check("short_glitch_display", {16'd0, display_output}, 32'd4465);
    check("short_glitch_complete", {31'd0, complete}, 32'd1);
    check("short_glitch_state", {30'd0, input_state_FPGA}, 32'd0);

    // Exactly the debounce length: a row-0 key is accepted and leaves DONE.
    seen_kp = 1'b0;
    @(negedge clk);
    glitch = 1'b1;
    repeat (4) @(negedge clk);
    glitch = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (key_pressed) seen_kp = 1'b1;
    end
    $display("full glitch: key_pressed_seen=%0b complete=%0b", seen_kp, complete);
    check("full_glitch_key", {31'd0, seen_kp}, 32'd1);
    check("full_glitch_leaves_done", {31'd0, complete}, 32'd0);

    // Reset mid-entry discards everything.
    @(negedge clk);
    nRST = 1'b1;
    repeat (2) @(negedge clk);
    nRST = 1'b0;
    repeat (2) @(negedge clk);
    run_keys("12", 1'b0);
    $display("entry 12: display=%0h", display_output);
    check("entry_12", {16'd0, display_output}, 32'd12);
    nRST = 1'b1;
    #1;
    check("async_reset_display", {16'd0, display_output}, 32'd0);
    repeat (2) @(negedge clk);
    check_reset_state("midop_reset");
    nRST = 1'b0;
    repeat (2) @(negedge clk);
    run_keys("5A5*", 1'b1);
    $display("after reset 5A5*: display=%0h complete=%0b", display_output, complete);
    check("post_reset_disp", {16'd0, display_output}, 32'd10);
    check("post_reset_done", {31'd0, complete}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
